queue_ctrl: RTL
===============

Name: queue_ctrl

Overview:
- Two-client access controller for the 8-bit bidirectional-bus queue (ports io, en, rw, empty, full).
- Accepts push/pop requests from two clients and arbitrates them round-robin.
- Rejects illegal operations: push when full, pop when empty.
- Drives the queue's en/rw strobes and the shared tri-state io bus, and returns pop data to the winning client.

Parameters:
- DW, 8, data width; equals the queue io width.
- TURN, 1, idle bus-turnaround cycles after each response; legal range 0-7.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous active-low reset. The same net also feeds the queue's reset_n.
- req0  input  1  client 0 request; held high until ack0.
- op0  input  1  client 0 operation: 1 = push, 0 = pop. Stable while req0 is high.
- wdata0  input  DW  client 0 push data. Stable while req0 is high.
- ack0  output  1  client 0 completion, one-cycle pulse.
- err0  output  1  client 0 rejected; valid with ack0.
- req1, op1, wdata1, ack1, err1: same as client 0, for client 1.
- rdata  output  DW  pop data; valid in the ack cycle, held until the next ack.
- q_en  output  1  queue enable strobe.
- q_rw  output  1  queue direction: 1 = write (push), 0 = read (pop).
- q_io  inout  DW  queue data bus. Driven only during a push ACCESS cycle, otherwise high-Z.
- q_empty  input  1  queue empty flag.
- q_full  input  1  queue full flag.

Behaviour:
- FSM states: IDLE, ACCESS, RESP, TURN. All outputs are registered except q_io's tri-state enable, which is decoded from state.
- Reset (synchronous, reset_n=0 at a clk edge):
  - state = IDLE; q_en = 0; q_rw = 0; q_io = Z.
  - ack0/1 = 0; err0/1 = 0; rdata = 0.
  - Round-robin pointer = 1, so client 0 wins the first tie.
  - Reset mid-operation aborts immediately, with no ack. The queue is reset on the same edge, so no partial access remains.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that client.
  - If both are high, grant the client not named by the pointer, then set the pointer to the granted client. The pointer also updates on rejected grants.
  - On the grant edge, latch the winner's op, wdata and client id.
  - If push with q_full=1, or pop with q_empty=1: set err = 1, go to RESP, and do not access the queue.
  - Otherwise go to ACCESS.
- ACCESS (exactly 1 cycle):
  - q_en = 1 and q_rw = latched op.
  - Push: q_io = latched wdata.
  - Pop: q_io = Z, and q_io is sampled into rdata at the end of the cycle.
  - q_en is never high for two consecutive cycles, because the queue pointers advance once per enabled edge.
- RESP (1 cycle):
  - Granted client's ack = 1; err = 1 only on rejection.
  - The other client's ack/err = 0.
  - q_en = 0 and q_io = Z.
  - rdata updates only on a successful pop; a rejected pop leaves rdata unchanged.
- TURN:
  - Lasts TURN cycles; with TURN=0 it is skipped (RESP goes straight to IDLE). q_io = Z.
  - A request still high when IDLE is re-entered is treated as a new request. Clients must drop req in the cycle after ack.
- Latency:
  - Request seen in IDLE at edge t: q_en high t+1, ack high t+2.
  - Next grant at the earliest t+3+TURN.
- Full/empty flags are sampled only at the grant edge. A push that fills the queue is reflected on the next grant via q_full.
- Requests arriving in ACCESS, RESP or TURN are ignored until IDLE. There are no drops: req is level-held.
- No bus contention: q_io is driven only in a push ACCESS cycle.

Test Plan:
- Reset, empty queue: req0=1, op0=1, wdata0=0x5A.
  - Required: q_en=1 and q_rw=1 with q_io=0x5A exactly one cycle later; ack0=1, err0=0 the following cycle.
- Following the push, req1=1, op1=0.
  - Required: one q_en pulse with q_rw=0 and q_io=Z; then ack1=1, rdata=0x5A, err1=0.
  - q_empty=1 afterwards.
- Queue empty, req0 pop.
  - Required: ack0=1, err0=1; no q_en pulse; rdata unchanged.
- Fill the queue until q_full=1, then req1 push 0x33.
  - Required: ack1=1, err1=1; no q_en pulse.
  - Pop the next entry: it returns the oldest data, not 0x33.
- req0 and req1 held high continuously with pushes 0x01/0x02, TURN=1.
  - Required grant order 0,1,0,1; ack pulses spaced 4 cycles apart.
  - Pop order returns 0x01,0x02,0x01,0x02.
- reset_n=0 asserted in the ACCESS cycle.
  - Required at the next edge: all outputs 0, q_io=Z, no ack.
  - After release, req1 and req0 both high: client 0 is granted first.

Source files
------------

// File: rtl/queue_ctrl_if.sv
// Client-side handshake bundle for the two-client queue access controller.
// The client drives req/op/wdata and the controller returns ack/err/rdata.
interface queue_ctrl_if #(
    parameter int DW = 8
);
    logic          req0;
    logic          op0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    logic          err0;
    logic          req1;
    logic          op1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    logic          err1;
    logic [DW-1:0] rdata;

    modport master (
        output req0, op0, wdata0, req1, op1, wdata1,
        input  ack0, err0, ack1, err1, rdata
    );

    modport slave (
        input  req0, op0, wdata0, req1, op1, wdata1,
        output ack0, err0, ack1, err1, rdata
    );
endinterface

// File: rtl/queue_ctrl.sv
// Round-robin two-client access controller for a bidirectional-bus queue.
// Rejects push-when-full and pop-when-empty without touching the queue.
module queue_ctrl #(
    parameter int DW   = 8,
    parameter int TURN = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    queue_ctrl_if.slave   cli,
    output logic          q_en,
    output logic          q_rw,
    inout  wire  [DW-1:0] q_io,
    input  logic          q_empty,
    input  logic          q_full
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2,
        S_TURN   = 2'd3
    } state_t;

    localparam logic [2:0] TURN_LAST = 3'((TURN > 0) ? (TURN - 1) : 0);

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          id_q, id_d;
    logic          op_q, op_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          q_en_q, q_en_d;
    logic          q_rw_q, q_rw_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          err0_q, err0_d;
    logic          err1_q, err1_d;

    logic          grant_s;
    logic          sel_op_s;
    logic [DW-1:0] sel_wdata_s;
    logic          reject_s;

    // Arbitration: on a tie the client not named by the pointer wins.
    always_comb begin
        grant_s     = 1'b0;
        sel_op_s    = 1'b0;
        sel_wdata_s = {DW{1'b0}};
        reject_s    = 1'b0;
        if (cli.req0 && cli.req1) begin
            grant_s = ~ptr_q;
        end else begin
            grant_s = cli.req1;
        end
        if (grant_s) begin
            sel_op_s    = cli.op1;
            sel_wdata_s = cli.wdata1;
        end else begin
            sel_op_s    = cli.op0;
            sel_wdata_s = cli.wdata0;
        end
        reject_s = sel_op_s ? q_full : q_empty;
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        q_en_d  = 1'b0;
        q_rw_d  = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err0_d  = 1'b0;
        err1_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cli.req0 || cli.req1) begin
                    ptr_d   = grant_s;
                    id_d    = grant_s;
                    op_d    = sel_op_s;
                    wdata_d = sel_wdata_s;
                    if (reject_s) begin
                        // Rejected grants skip the queue and answer immediately.
                        state_d = S_RESP;
                        ack0_d  = ~grant_s;
                        err0_d  = ~grant_s;
                        ack1_d  = grant_s;
                        err1_d  = grant_s;
                    end else begin
                        state_d = S_ACCESS;
                        q_en_d  = 1'b1;
                        q_rw_d  = sel_op_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                if (!op_q) begin
                    rdata_d = q_io;
                end else begin
                    rdata_d = rdata_q;
                end
                if (id_q) begin
                    ack1_d = 1'b1;
                end else begin
                    ack0_d = 1'b1;
                end
            end
            S_RESP: begin
                if (TURN == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_TURN;
                    cnt_d   = TURN_LAST;
                end
            end
            S_TURN: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b1;
            id_q    <= 1'b0;
            op_q    <= 1'b0;
            wdata_q <= {DW{1'b0}};
            rdata_q <= {DW{1'b0}};
            cnt_q   <= 3'd0;
            q_en_q  <= 1'b0;
            q_rw_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            q_en_q  <= q_en_d;
            q_rw_q  <= q_rw_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

    // The bus is only ever driven while a push is being strobed into the queue.
    assign q_io      = ((state_q == S_ACCESS) && op_q) ? wdata_q : {DW{1'bz}};
    assign q_en      = q_en_q;
    assign q_rw      = q_rw_q;
    assign cli.ack0  = ack0_q;
    assign cli.ack1  = ack1_q;
    assign cli.err0  = err0_q;
    assign cli.err1  = err1_q;
    assign cli.rdata = rdata_q;

endmodule
